// File: rtl/rv32i_loader_pkg.sv
// Shared types and RV32I encoding constants for the boot-time program loader.
package rv32i_loader_pkg;

   typedef enum logic [2:0] {
      K_ADDI = 3'd0,
      K_ADD  = 3'd1,
      K_BNE  = 3'd2,
      K_LW   = 3'd3,
      K_SW   = 3'd4,
      K_LUI  = 3'd5
   } instr_kind_t;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_LSW = 3'b010;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [6:0] F7_ADD = 7'b0000000;

   typedef enum logic [1:0] {
      E_NONE = 2'd0,
      E_KIND = 2'd1,
      E_IMM  = 2'd2,
      E_FULL = 2'd3
   } loader_err_t;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_DONE = 2'd1,
      S_ERR  = 2'd2
   } loader_state_t;

   // True when bits [31:lsb] are a pure sign extension (all ones or all zeros).
   function automatic logic sext_ok12(input logic [31:0] v);
      return (&v[31:11]) | ~(|v[31:11]);
   endfunction

   function automatic logic sext_ok13(input logic [31:0] v);
      return (&v[31:12]) | ~(|v[31:12]);
   endfunction

endpackage

// File: rtl/rv32i_instr_encoder.sv
// Combinational symbolic-to-RV32I encoder with immediate range/alignment check.
module rv32i_instr_encoder
   import rv32i_loader_pkg::*;
(
   input  logic [2:0]  i_kind,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [31:0] i_imm,
   output logic [31:0] o_word,
   output logic        o_illegal_kind,
   output logic        o_imm_bad
);

   always_comb begin
      o_word         = '0;
      o_illegal_kind = 1'b0;
      o_imm_bad      = 1'b0;
      case (i_kind)
         K_ADDI: begin
            o_word    = {i_imm[11:0], i_rs1, F3_ADD, i_rd, OP_IMM};
            o_imm_bad = ~sext_ok12(i_imm);
         end
         K_ADD:
            o_word = {F7_ADD, i_rs2, i_rs1, F3_ADD, i_rd, OP_REG};
         K_BNE: begin
            // B-type scatters the halfword offset; bit 0 must be zero.
            o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BNE,
                         i_imm[4:1], i_imm[11], OP_BRANCH};
            o_imm_bad = ~sext_ok13(i_imm) | i_imm[0];
         end
         K_LW: begin
            o_word    = {i_imm[11:0], i_rs1, F3_LSW, i_rd, OP_LOAD};
            o_imm_bad = ~sext_ok12(i_imm);
         end
         K_SW: begin
            o_word    = {i_imm[11:5], i_rs2, i_rs1, F3_LSW, i_imm[4:0], OP_STORE};
            o_imm_bad = ~sext_ok12(i_imm);
         end
         K_LUI: begin
            o_word    = {i_imm[31:12], i_rd, OP_LUI};
            o_imm_bad = |i_imm[11:0];
         end
         default:
            o_illegal_kind = 1'b1;
      endcase
   end

endmodule

// File: rtl/rv32i_prog_loader.sv
// Streams encoded instructions into imem from address 0 and holds the core in
// reset until the program is complete.
module rv32i_prog_loader
   import rv32i_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_kind,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [31:0]           in_imm,
   input  logic                  in_last,
   output logic                  mem_we,
   output logic [ADDR_WIDTH+1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_rst_hold,
   output logic                  done,
   output logic                  err,
   output logic [1:0]            err_code
);

   loader_state_t         r_state, w_state_nxt;
   loader_err_t           r_err_code, w_err_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_we;
   logic [ADDR_WIDTH+1:0] r_addr;
   logic [31:0]           r_wdata;
   logic                  r_fin;
   logic                  r_full;

   logic [31:0] w_word;
   logic        w_illegal, w_imm_bad, w_xfer, w_fault, w_wr, w_at_end;

   rv32i_instr_encoder u_enc (
      .i_kind         (in_kind),
      .i_rd           (in_rd),
      .i_rs1          (in_rs1),
      .i_rs2          (in_rs2),
      .i_imm          (in_imm),
      .o_word         (w_word),
      .o_illegal_kind (w_illegal),
      .o_imm_bad      (w_imm_bad)
   );

   // r_fin closes the input for the cycle in which the final write is on the bus.
   assign in_ready = (r_state == S_LOAD) && !r_fin;
   assign w_xfer   = in_valid && in_ready;
   assign w_fault  = w_illegal || w_imm_bad;
   assign w_wr     = w_xfer && !w_fault;
   assign w_at_end = &r_cnt;

   always_comb begin
      w_state_nxt = r_state;
      w_err_nxt   = r_err_code;
      if (r_state == S_LOAD) begin
         if (r_fin) begin
            w_state_nxt = r_full ? S_ERR : S_DONE;
            if (r_full) w_err_nxt = E_FULL;
         end else if (w_xfer && w_fault) begin
            w_state_nxt = S_ERR;
            w_err_nxt   = w_illegal ? E_KIND : E_IMM;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_LOAD;
         r_err_code <= E_NONE;
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_fin      <= 1'b0;
         r_full     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_err_code <= w_err_nxt;
         r_we       <= w_wr;
         if (w_wr) begin
            r_addr  <= {r_cnt, 2'b00};
            r_wdata <= w_word;
            r_cnt   <= r_cnt + 1'b1;
            r_fin   <= in_last || w_at_end;
            r_full  <= !in_last && w_at_end;
         end
      end
   end

   assign mem_we       = r_we;
   assign mem_addr     = r_addr;
   assign mem_wdata    = r_wdata;
   assign done         = (r_state == S_DONE);
   assign err          = (r_state == S_ERR);
   assign cpu_rst_hold = (r_state != S_DONE);
   assign err_code     = r_err_code;

endmodule

// File: doc/rv32i_prog_loader.md
Name: rv32i_prog_loader

Overview:
- Boot-time program writer for the single-cycle RV32I core; the encoding counterpart of the control unit's decode.
- Accepts a stream of symbolic instructions (kind, register fields, immediate) over a valid/ready handshake.
- Encodes each into a 32-bit RV32I word and writes it sequentially into instruction memory from address 0.
- Holds the CPU in reset until the program is fully written.

Parameters:
ADDR_WIDTH, 8, word-address width of instruction memory; DEPTH = 2**ADDR_WIDTH words

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
in_valid  input  1  instruction request valid
in_ready  output  1  loader can accept a request this cycle
in_kind  input  3  0 ADDI, 1 ADD, 2 BNE, 3 LW, 4 SW, 5 LUI, 6-7 illegal
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  32  immediate, full signed byte value (LUI: final upper value)
in_last  input  1  marks final instruction of program
mem_we  output  1  instruction memory write enable
mem_addr  output  ADDR_WIDTH+2  byte address, bits [1:0] always 0
mem_wdata  output  32  encoded instruction word
cpu_rst_hold  output  1  holds core in reset while high
done  output  1  program loaded successfully
err  output  1  load aborted
err_code  output  2  0 none, 1 illegal kind, 2 immediate out of range or misaligned, 3 memory full

Behaviour:
- States: LOAD, DONE, ERR. Reset enters LOAD.
- Reset values:
  - in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_rst_hold=1, done=0, err=0, err_code=0
  - word counter=0
- rst mid-load discards all progress; the next write is to address 0.
- LOAD:
  - in_ready is high. A transfer occurs when in_valid && in_ready.
  - Transfer in cycle N produces, in cycle N+1: mem_we=1, mem_addr=counter*4, mem_wdata=encoded word. The counter increments.
  - One transfer per cycle is sustainable. mem_we is low in any cycle without a preceding transfer.
- Encodings:
  - ADDI: opcode 0010011, f3 000
  - ADD: opcode 0110011, f3 000, f7 0000000
  - LW: opcode 0000011, f3 010
  - SW: opcode 0100011, f3 010, imm split [11:5]/[4:0]
  - BNE: opcode 1100011, f3 001, imm[12|10:5] rs2 rs1 f3 imm[4:1|11]
  - LUI: opcode 0110111, in_imm[31:12]
- Unused fields encode as 0; e.g. ADDI ignores rs2.
- Legality is checked at transfer:
  - ADDI/LW/SW: in_imm[31:11] all equal
  - BNE: in_imm[31:12] all equal and in_imm[0]=0
  - LUI: in_imm[11:0]=0
  - kind 6/7: illegal
- Faulting transfer:
  - No write is issued for it.
  - Next cycle: state ERR, err=1, err_code set, in_ready=0.
- in_last on a legal transfer:
  - Its write occurs in N+1.
  - in_ready=0 from N+1.
  - In N+2: state DONE, done=1, cpu_rst_hold=0.
- Full:
  - If the legal transfer writes address DEPTH-1 and in_last=0, the write still occurs.
  - Next cycle: ERR with err_code=3.
  - DEPTH-1 with in_last=1 is a normal DONE.
- DONE and ERR are sticky until rst. In both, in_ready=0 and mem_we=0. cpu_rst_hold stays 1 in ERR.
- in_valid while in_ready=0 is ignored; no side effects.

Decomposition:
- Package rv32i_loader_pkg:
  - instr_kind_t enum
  - opcode/funct3/funct7 localparams
  - loader_err_t enum
  - loader_state_t enum
- Sub-module rv32i_instr_encoder: purely combinational. kind, regs and imm in; word, illegal_kind and imm_bad out. Reusable by the testbench reference model.
- Top holds the FSM, counter and output registers.

Test Plan:
- Stream 6 transfers with in_last on the last, then check the 6 writes:
  - ADDI x1,x0,5 → word 0x00500093 at addr 0x00
  - ADD x3,x1,x2 → word 0x002081B3 at addr 0x04
  - BNE x1,x2,-8 → word 0xFE209CE3 at addr 0x08
  - LW x5,-4(x1) → word 0xFFC0A283 at addr 0x0C
  - SW x2,4(x1) → word 0x0020A223 at addr 0x10
  - LUI x4,0x12345000 → word 0x12345237 at addr 0x14
  - done=1 and cpu_rst_hold=0 two cycles after the last transfer.
- Back-to-back versus gapped in_valid → writes occur one cycle after each transfer only; addresses stay contiguous.
- ADDI with imm=2048 as 2nd word → one write only, then err=1, err_code=2, cpu_rst_hold=1, in_ready=0. Same check for BNE imm=-7 and for kind=6 (err_code=1).
- ADDR_WIDTH=2, 5 legal transfers with no in_last → 4 writes (0x0-0xC), err_code=3 after the 4th; the 5th is not accepted.
- Assert rst after 3 writes, then load 2 words with in_last → writes at 0x0 and 0x4, done=1; no output glitch during reset.
- In DONE, drive in_valid for 10 cycles → in_ready=0, no mem_we, done stays 1.
